// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
// SPI mode-0 master that sends one traffic-light register write as a framed
// 10-bit shift sequence: 0, 1 (start), wen, addr[1:0], data[2:0], 0, 0.
// Each frame is followed by a select-high gap in which sclk keeps running
// so the slave flushes its shift register.
//
// Ports
//   clk       system clock, all logic on its rising edge
//   rst       synchronous, active-high reset
//   req       write request valid (accepted when req && ready)
//   addr      register address to send
//   data      register data to send
//   wen       write-enable bit to send
//   ready     idle and able to accept req
//   done      one-cycle pulse when a transaction completes
//   rx_data   spi_miso captured on the 10 in-frame sclk rising edges, first in MSB
//   spi_sclk  SPI clock, idles low, registered
//   spi_mosi  SPI data out, changes only while spi_sclk is low
//   spi_ss_n  active-low slave select
//   spi_miso  SPI data in
// -----------------------------------------------------------------------------
module spi_master_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] addr,
  input  logic [2:0] data,
  input  logic       wen,
  output logic       ready,
  output logic       done,
  output logic [9:0] rx_data,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_ss_n,
  input  logic       spi_miso
);

  localparam int                DIV_W   = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,   // select low, 10 bits shifted out
    GAP,     // select high, sclk still running for 2 periods
    DONE     // single completion cycle, can accept the next request
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_idx;    // bit index in SHIFT, falling-edge count in GAP
  logic [9:0]       shreg;      // bit 9 is the bit currently on mosi
  logic [9:0]       rx_q;
  logic             sclk_q;

  logic accept;
  logic busy;
  logic div_last;
  logic sclk_rise;
  logic sclk_fall;

  assign accept    = req && ready;
  assign busy      = (state == SHIFT) || (state == GAP);
  assign div_last  = (div_cnt == DIV_MAX);
  // Rise/fall are the cycles in which the registered sclk is about to toggle.
  assign sclk_rise = busy && div_last && !sclk_q;
  assign sclk_fall = busy && div_last &&  sclk_q;

  assign spi_sclk = sclk_q;
  assign rx_data  = rx_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    spi_ss_n  = 1'b1;
    spi_mosi  = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        spi_ss_n = 1'b0;
        spi_mosi = shreg[9];
        if (sclk_fall && bit_idx == 4'd9) state_nxt = GAP;
      end
      GAP: begin
        if (sclk_fall && bit_idx == 4'd1) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = accept ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_q    <= '0;
    end else if (accept) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      bit_idx <= '0;
      shreg   <= {2'b01, wen, addr, data, 2'b00};
    end else if (busy) begin
      div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
      if (div_last) sclk_q <= ~sclk_q;
      if (sclk_rise && state == SHIFT) rx_q <= {rx_q[8:0], spi_miso};
      if (sclk_fall) begin
        if (state == SHIFT) begin
          // mosi moves to the next bit together with sclk going low.
          shreg   <= {shreg[8:0], 1'b0};
          bit_idx <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
        end
      end
    end else begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      bit_idx <= '0;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_master_tx
// Self-checking bench for spi_master_tx. One instance with CLK_DIV=4 is
// watched by a slave model whose decoded frames are compared against a
// queue of expected writes; a second instance with CLK_DIV=1 checks the
// miso capture path.
// -----------------------------------------------------------------------------
module tb_spi_master_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // CLK_DIV = 4 instance
  logic       req4 = 1'b0, wen4 = 1'b0, miso4 = 1'b0;
  logic [1:0] addr4 = '0;
  logic [2:0] data4 = '0;
  logic       ready4, done4, sclk4, mosi4, ss4;
  logic [9:0] rx4;

  // CLK_DIV = 1 instance
  logic       req1 = 1'b0, wen1 = 1'b0, miso1 = 1'b0;
  logic [1:0] addr1 = '0;
  logic [2:0] data1 = '0;
  logic       ready1, done1, sclk1, mosi1, ss1;
  logic [9:0] rx1;

  spi_master_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .addr(addr4), .data(data4), .wen(wen4),
    .ready(ready4), .done(done4), .rx_data(rx4), .spi_sclk(sclk4),
    .spi_mosi(mosi4), .spi_ss_n(ss4), .spi_miso(miso4)
  );

  spi_master_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr1), .data(data1), .wen(wen1),
    .ready(ready1), .done(done1), .rx_data(rx1), .spi_sclk(sclk1),
    .spi_mosi(mosi1), .spi_ss_n(ss1), .spi_miso(miso1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave model + scoreboard for the CLK_DIV=4 instance
  // ---------------------------------------------------------------------------
  logic [5:0] exp_q[$];          // {wen, addr, data}
  logic [5:0] exp_w;
  logic [9:0] cap4      = '0;
  int         nbits4    = 0;
  int         writes    = 0;
  int         discards  = 0;
  int         edge_viol = 0;
  int         dones4    = 0;
  int         ss_fall_cyc = 0;
  int         ss_rise_cyc = 0;
  int         min_high  = 1000;
  logic       track_gap = 1'b0;
  logic       prev_sclk4 = 1'b0, prev_mosi4 = 1'b0, prev_ss4 = 1'b1;

  always @(negedge clk) begin
    if (sclk4 && !prev_sclk4) begin
      if (mosi4 !== prev_mosi4 || ss4 !== prev_ss4) edge_viol++;
      if (!ss4) begin
        cap4 = {cap4[8:0], mosi4};
        nbits4++;
      end
    end
    if (!ss4 && prev_ss4) begin
      ss_fall_cyc = cyc;
      if (track_gap && (cyc - ss_rise_cyc) < min_high) min_high = cyc - ss_rise_cyc;
    end
    if (ss4 && !prev_ss4) begin
      ss_rise_cyc = cyc;
      if (nbits4 == 10) begin
        writes++;
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("mosi_frame", cap4, {2'b01, exp_w, 2'b00});
          check("slave_write", {cap4[7], cap4[6:5], cap4[4:2]}, exp_w);
        end
      end else begin
        discards++;
      end
      nbits4 = 0;
    end
    if (done4) dones4++;
    prev_sclk4 = sclk4;
    prev_mosi4 = mosi4;
    prev_ss4   = ss4;
  end

  // ---------------------------------------------------------------------------
  // miso driver for the CLK_DIV=1 instance: new bit while sclk is low
  // ---------------------------------------------------------------------------
  logic [9:0] miso_pat  = 10'b1010110011;
  logic       miso_en   = 1'b0;
  logic       prev_sclk1 = 1'b0;
  int         rises1    = 0;

  always @(negedge clk) begin
    if (ss1) rises1 = 0;
    else if (sclk1 && !prev_sclk1) rises1++;
    if (!miso_en) miso1 = 1'b0;
    else if (!ss1 && !sclk1 && rises1 < 10) miso1 = miso_pat[9-rises1];
    prev_sclk1 = sclk1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send4(input logic w, input logic [1:0] a, input logic [2:0] d,
                       input bit push, output int t);
    int n;
    wen4 = w; addr4 = a; data4 = d; req4 = 1'b1;
    n = 0;
    while (!ready4 && n < 200) begin step(); n++; end
    check("send4_ready", ready4, 1);
    t = cyc;
    if (push) exp_q.push_back({w, a, d});
    step();
    req4 = 1'b0;
  endtask

  task automatic wait_done4(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done4) begin at = cyc; break; end
      step();
    end
    check("done4_seen", at != -1, 1);
  endtask

  task automatic frame1(output int t, output int at);
    int n;
    wen1 = 1'b1; addr1 = 2'd1; data1 = 3'd6; req1 = 1'b1;
    n = 0;
    while (!ready1 && n < 50) begin step(); n++; end
    t = cyc;
    step();
    req1 = 1'b0;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      if (done1) begin at = cyc; break; end
      step();
    end
    check("done1_seen", at != -1, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int t, at, d0, w0, dc0, n;
  int ts[3];
  logic       pw[3] = '{1'b1, 1'b0, 1'b1};
  logic [1:0] pa[3] = '{2'd0, 2'd3, 2'd1};
  logic [2:0] pd[3] = '{3'd7, 3'd2, 3'd4};

  initial begin
    // Reset and idle
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset_rx4", rx4, 0);
    for (int i = 0; i < 50; i++) begin
      check("idle_outputs", {ready4, done4, ss4, sclk4, mosi4}, 5'b10100);
      step();
    end

    // Single frame wen=1 addr=2 data=5
    send4(1'b1, 2'd2, 3'd5, 1'b1, t);
    check("ss_low_t1", ss4, 0);
    check("ready_low_t1", ready4, 0);
    wait_done4(200, at);
    check("done_cycle", at, t + 97);
    check("ready_in_done", ready4, 1);
    check("ss_fall_cycle", ss_fall_cyc, t + 1);
    check("ss_rise_cycle", ss_rise_cyc, t + 81);
    step();
    check("done_one_cycle", done4, 0);

    // Three back-to-back frames with req held high
    d0 = dones4;
    track_gap = 1'b1;
    min_high  = 1000;
    for (int k = 0; k < 3; k++) begin
      wen4 = pw[k]; addr4 = pa[k]; data4 = pd[k]; req4 = 1'b1;
      n = 0;
      while (!ready4 && n < 200) begin step(); n++; end
      check("b2b_ready", ready4, 1);
      ts[k] = cyc;
      exp_q.push_back({pw[k], pa[k], pd[k]});
      step();
    end
    req4 = 1'b0;
    wait_done4(200, at);
    step();
    track_gap = 1'b0;
    check("b2b_interval_0", ts[1] - ts[0], 97);
    check("b2b_interval_1", ts[2] - ts[1], 97);
    check("b2b_done_count", dones4 - d0, 3);
    check("b2b_gap_ge_16", min_high >= 16, 1);
    repeat (5) step();

    // Reset on the 5th rising sclk edge
    w0 = writes; dc0 = discards;
    send4(1'b0, 2'd1, 3'd3, 1'b0, t);
    n = 0;
    while (nbits4 < 5 && n < 200) begin step(); n++; end
    check("abort_reached_5", nbits4, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_outputs", {ready4, done4, ss4, sclk4, mosi4}, 5'b10100);
    check("abort_rx4", rx4, 0);
    check("abort_no_write", writes - w0, 0);
    check("abort_discard", discards - dc0, 1);
    step();
    send4(1'b1, 2'd3, 3'd6, 1'b1, t);
    wait_done4(200, at);
    check("post_abort_done", at, t + 97);
    step();

    // CLK_DIV=1 miso capture
    miso_en = 1'b1;
    frame1(t, at);
    check("div1_done_cycle", at, t + 25);
    check("div1_rx_pattern", rx1, 10'b1010110011);
    step();
    miso_en = 1'b0;
    frame1(t, at);
    check("div1_rx_zero", rx1, 0);
    step();

    // Requests while busy are ignored
    d0 = dones4; w0 = writes;
    send4(1'b0, 2'd2, 3'd3, 1'b1, t);
    repeat (10) step();
    wen4 = 1'b1; addr4 = 2'd1; data4 = 3'd4; req4 = 1'b1;
    step();
    req4 = 1'b0;
    repeat (30) step();
    wen4 = 1'b1; addr4 = 2'd0; data4 = 3'd1; req4 = 1'b1;
    step();
    req4 = 1'b0;
    wait_done4(200, at);
    check("busy_done_cycle", at, t + 97);
    repeat (120) step();
    check("busy_one_done", dones4 - d0, 1);
    check("busy_one_write", writes - w0, 1);
    check("busy_idle_after", {ready4, ss4, sclk4}, 3'b110);

    // Totals
    check("sb_drained", exp_q.size(), 0);
    check("edge_violations", edge_viol, 0);
    check("total_writes", writes, 6);
    check("total_discards", discards, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 master that serialises one traffic-light register write into the 7-bit framed SPI format decoded by the slave-side receiver.
- Frame payload: start bit 1, wen, addr[1:0], data[2:0], MSB first.
- Sits in the controller/host side of the design. Accepts a write request via a valid/ready handshake, generates spi_sclk, spi_ss_n and spi_mosi, and captures spi_miso for loopback/status.

Parameters:
- CLK_DIV, 4, clk cycles per spi_sclk half-period. Legal values are 1 or more; spi_sclk = clk/(2*CLK_DIV).

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  write request valid
- addr  input  2  register address to send
- data  input  3  register data to send
- wen  input  1  write-enable bit to send
- ready  output  1  high when idle and able to accept req
- done  output  1  one-cycle pulse when a transaction fully completes
- rx_data  output  10  spi_miso bits captured on the 10 in-frame sclk rising edges, first bit in MSB
- spi_sclk  output  1  SPI clock, idles low
- spi_mosi  output  1  SPI data out; changes only while spi_sclk is low
- spi_ss_n  output  1  active-low slave select
- spi_miso  input  1  SPI data in

Behaviour:
- Reset (rst=1 at a clk edge), taking effect next cycle regardless of state:
  - ready=1, done=0, spi_ss_n=1, spi_sclk=0, spi_mosi=0, rx_data=0.
  - Divider counter and bit counter cleared; state IDLE.
  - Reset mid-frame aborts cleanly; the slave sees ss_n high and discards the partial frame.
- Handshake:
  - Accept when req=1 and ready=1 at a clk edge (cycle T). {wen,addr,data} latched into a 10-bit shift register as {0,1,wen,addr[1],addr[0],data[2],data[1],data[0],0,0}.
  - ready drops in T+1. req and inputs are ignored while ready=0; there is no queue.
- States:
  - IDLE: outputs at reset values, except rx_data holds its last value. On accept -> LEAD.
  - LEAD/SHIFT (one state plus 4-bit bit index 0..9): spi_ss_n=0 from T+1.
    - spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles, repeating; first rising edge at T+1+CLK_DIV.
    - spi_mosi = shift-register bit[index]. Bit 0 is presented at T+1; the index advances in the cycle spi_sclk falls.
    - spi_miso sampled into rx_data in the cycle spi_sclk rises.
    - After the falling edge ending bit 9 -> GAP.
  - GAP: spi_ss_n=1, spi_mosi=0, spi_sclk keeps toggling for 2 full periods (4*CLK_DIV cycles) so the slave flushes its shift register to 0. Then -> DONE.
  - DONE: single cycle; done=1, ready=1, state returns to IDLE. An accept in this same cycle is legal and starts the next frame; back-to-back requests are therefore allowed.
- Timing:
  - Busy span: 12 sclk periods. done=1 and ready=1 in cycle T+1+24*CLK_DIV (T+97 for CLK_DIV=4).
  - First payload start bit ('1') is sampled by the slave on the 2nd rising edge; bit '0' on the 1st edge provides the required 0->1 start transition.
- Edge constraints:
  - spi_mosi and spi_ss_n never change in the same cycle spi_sclk rises.
  - spi_sclk is a registered output; no glitches.
  - CLK_DIV=1 is legal: sclk toggles every cycle.
  - The divider counter is $clog2(CLK_DIV)+1 bits and wraps to 0 at CLK_DIV-1.
- Simultaneous rst and req: rst wins; no transaction starts.

Test Plan:
- Reset then idle 50 cycles -> ready=1, done=0, ss_n=1, sclk=0, mosi=0 throughout, no sclk edges.
- CLK_DIV=4; req with wen=1, addr=2'b10, data=3'b101 at T:
  - mosi sampled on the 10 rising edges = 0,1,1,1,0,1,0,1,0,0.
  - ss_n low from T+1 to the 10th falling edge.
  - done pulse at T+97.
  - Attached slave model outputs wen=1/addr=2/data=5 at frame end.
- req held high for 3 transactions with different payloads -> three frames back-to-back, each accepted in the DONE cycle. Each frame has ss_n high for at least 2 sclk periods between frames, and exactly 3 done pulses.
- rst asserted at the 5th rising sclk edge -> next cycle ss_n=1, sclk=0, mosi=0, ready=1. Slave model reports no write. A following req produces a correct full frame.
- CLK_DIV=1, spi_miso driven with pattern 1010110011 aligned to rising edges -> rx_data=10'b1010110011 at done. With spi_miso tied 0, rx_data=0.
- req pulsed while busy with a different payload -> ignored; only the original frame is sent and one done occurs.
